// File: rtl/bcd_tick_counter.sv
// Clock-divided timebase driving an N-digit up/down BCD counter with tick/carry pulses.
// Optional lap capture register enabled by defining BCD_TICK_COUNTER_LAP_EN.
module bcd_tick_counter #(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned TICK_HZ = 1000,
  parameter int unsigned DIGITS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
`ifdef BCD_TICK_COUNTER_LAP_EN
  input  logic                  lap,
  output logic [4*DIGITS-1:0]   lap_count,
`endif
  output logic [4*DIGITS-1:0]   count,
  output logic                  tick,
  output logic                  carry
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV >= 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam int unsigned CW  = 4 * DIGITS;

  if ((CLK_HZ % TICK_HZ) != 0 || DIV < 2 || DIGITS < 1 || DIGITS > 8) begin : g_param_check
    $error("bcd_tick_counter: CLK_HZ must be a multiple of TICK_HZ, DIV >= 2, DIGITS in 1..8");
  end

  logic [PW-1:0] pre_q;
  logic [CW-1:0] count_q;
  logic          tick_q;
  logic          carry_q;

  logic [CW-1:0] step_val;
  logic          step_wrap;
  logic          ripple;
  logic [CW-1:0] load_clean;

  // Ripple a single +1/-1 through the decades; a carry/borrow surviving every
  // digit means the whole count wrapped.
  always_comb begin
    step_val = count_q;
    ripple   = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (ripple) begin
        if (up) begin
          if (count_q[4*i +: 4] == 4'd9) begin
            step_val[4*i +: 4] = '0;
          end else begin
            step_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
            ripple             = 1'b0;
          end
        end else begin
          if (count_q[4*i +: 4] == 4'd0) begin
            step_val[4*i +: 4] = 4'd9;
          end else begin
            step_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
            ripple             = 1'b0;
          end
        end
      end
    end
    step_wrap = ripple;
  end

  always_comb begin
    load_clean = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      load_clean[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd0 : load_val[4*i +: 4];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q   <= '0;
      count_q <= '0;
      tick_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      tick_q  <= 1'b0;
      carry_q <= 1'b0;
      if (clr) begin
        pre_q   <= '0;
        count_q <= '0;
      end else if (load) begin
        pre_q   <= '0;
        count_q <= load_clean;
      end else if (en) begin
        if (pre_q == PRE_LAST) begin
          pre_q   <= '0;
          count_q <= step_val;
          tick_q  <= 1'b1;
          carry_q <= step_wrap;
        end else begin
          pre_q <= pre_q + PW'(1);
        end
      end
    end
  end

`ifdef BCD_TICK_COUNTER_LAP_EN
  logic [CW-1:0] lap_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lap_q <= '0;
    end else if (lap) begin
      lap_q <= count_q;
    end
  end

  assign lap_count = lap_q;
`endif

  assign count = count_q;
  assign tick  = tick_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Scoreboard bench for bcd_tick_counter (DIV=10, DIGITS=2) against an integer reference model.
module tb_bcd_tick_counter;

  localparam int DIV = 10;
  localparam int MOD = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, clr, up, load;
  logic [7:0] load_val;
  logic       lap;
  logic [7:0] count;
  logic       tick, carry;
`ifdef BCD_TICK_COUNTER_LAP_EN
  logic [7:0] lap_count;
`endif

  bcd_tick_counter #(
    .CLK_HZ (10),
    .TICK_HZ(1),
    .DIGITS (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clr      (clr),
    .up       (up),
    .load     (load),
    .load_val (load_val),
`ifdef BCD_TICK_COUNTER_LAP_EN
    .lap      (lap),
    .lap_count(lap_count),
`endif
    .count    (count),
    .tick     (tick),
    .carry    (carry)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] cnt;
    logic       tick;
    logic       carry;
    logic [7:0] lap;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: plain decimal value and cycle phase within the tick interval.
  int         m_cnt;
  int         m_pre;
  logic [7:0] m_lap;

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int from_load(input logic [7:0] lv);
    int d0, d1;
    d0 = (lv[3:0] > 4'd9) ? 0 : int'(lv[3:0]);
    d1 = (lv[7:4] > 4'd9) ? 0 : int'(lv[7:4]);
    return d1 * 10 + d0;
  endfunction

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_pre = 0;
    m_lap = 8'h00;
  endtask

  task automatic drive(input logic e, input logic c, input logic l, input logic u,
                       input logic [7:0] lv, input logic lp);
    exp_t x;
    @(negedge clk);
    en = e; clr = c; load = l; up = u; load_val = lv; lap = lp;
    x.tick  = 1'b0;
    x.carry = 1'b0;
    if (lp) m_lap = to_bcd(m_cnt);
    if (c) begin
      m_cnt = 0;
      m_pre = 0;
    end else if (l) begin
      m_cnt = from_load(lv);
      m_pre = 0;
    end else if (e) begin
      if (m_pre == DIV - 1) begin
        m_pre  = 0;
        x.tick = 1'b1;
        if (u) begin
          x.carry = (m_cnt == MOD - 1);
          m_cnt   = (m_cnt + 1) % MOD;
        end else begin
          x.carry = (m_cnt == 0);
          m_cnt   = (m_cnt + MOD - 1) % MOD;
        end
      end else begin
        m_pre++;
      end
    end
    x.cnt = to_bcd(m_cnt);
    x.lap = m_lap;
    q.push_back(x);
  endtask

  task automatic run(input int n, input logic u);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, u, 8'h00, 1'b0);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    rst = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0; lap = 1'b0;
    #1;
    check8("async_rst_count", count, 8'h00);
    check8("async_rst_tick", {7'd0, tick}, 8'h00);
    check8("async_rst_carry", {7'd0, carry}, 8'h00);
`ifdef BCD_TICK_COUNTER_LAP_EN
    check8("async_rst_lap", lap_count, 8'h00);
`endif
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: outputs are valid every clock; compare just after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check8("count", count, e.cnt);
        check8("tick", {7'd0, tick}, {7'd0, e.tick});
        check8("carry", {7'd0, carry}, {7'd0, e.carry});
`ifdef BCD_TICK_COUNTER_LAP_EN
        check8("lap_count", lap_count, e.lap);
`endif
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; en = 1'b0; clr = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'h00; lap = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check8("reset_count", count, 8'h00);
    check8("reset_tick", {7'd0, tick}, 8'h00);
    check8("reset_carry", {7'd0, carry}, 8'h00);
    rst = 1'b1;

    // First tick after DIV enabled cycles, then every DIV.
    run(35, 1'b1);

    // Up wrap 0x99 -> 0x00.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h98, 1'b0);
    run(25, 1'b1);

    // Down wrap 0x00 -> 0x99, then decade borrow.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 1'b0);
    run(25, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 1'b0);
    run(12, 1'b0);

    // Load sanitising, clr beats load, clr on the wrap edge.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'hA7, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'hFC, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h55, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h30, 1'b0);
    run(9, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
    run(12, 1'b1);

    // Enable gap of 3 cycles mid-interval stretches the interval to 13.
    run(5, 1'b1);
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    run(20, 1'b1);

    // Direction change mid-interval keeps prescaler phase.
    run(4, 1'b1);
    run(16, 1'b0);

    async_reset();
    run(15, 1'b1);

`ifdef BCD_TICK_COUNTER_LAP_EN
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h42, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
    run(15, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1);
    run(5, 1'b1);
`endif

    // Randomised traffic, biased toward near-wrap loads.
    for (int i = 0; i < 600; i++) begin
      logic       e, c, l, u, lp;
      logic [7:0] lv;
      e  = ($urandom_range(0, 9) < 8);
      c  = ($urandom_range(0, 59) == 0);
      l  = ($urandom_range(0, 29) == 0);
      u  = ($urandom_range(0, 1) == 1);
      lp = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0:       lv = 8'h99;
        1:       lv = 8'h00;
        default: lv = 8'($urandom);
      endcase
      drive(e, c, l, u, lv, lp);
    end

    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check8("scoreboard_drained", 8'(q.size()), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
